// File: rtl/l_class_oc_echo_indication_output.sv
// Echo indication transmit marshaller: buffers heard(meth, v) calls in a small FIFO
// and serializes each into a 96-bit {v, meth, tag} message on the outbound pipe.
module l_class_oc_echo_indication_output #(
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] HEARD_TAG = 32'd1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        indication_heard__ENA,
  input  logic [31:0] indication_heard_meth,
  input  logic [31:0] indication_heard_v,
  output logic        indication_heard__RDY,
  output logic        pipe_enq__ENA,
  output logic [95:0] pipe_enq_v,
  input  logic        pipe_enq__RDY,
  input  logic        rule_enable,
  output logic        rule_ready,
  output logic [31:0] sent_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   sent_q, sent_d;

  logic        accept;
  logic        guard;
  logic        fire;
  logic        not_empty;
  logic [63:0] head;

  // Ready and guard come from registered occupancy only, so no ENA-to-output path.
  assign not_empty = (count_q != '0);
  assign indication_heard__RDY = (count_q != FULL_CNT);
  assign guard  = not_empty & pipe_enq__RDY;
  assign accept = indication_heard__ENA & indication_heard__RDY;
  assign fire   = rule_enable & guard;

  assign rule_ready    = guard;
  assign pipe_enq__ENA = fire;
  assign sent_count    = sent_q;

  // Entries are stored as {meth, v}; the wire format reorders to {v, meth, tag}.
  assign head       = mem_q[rd_ptr_q];
  assign pipe_enq_v = not_empty ? {head[31:0], head[63:32], HEARD_TAG} : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    sent_d   = sent_q;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (fire) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      sent_d   = sent_q + 32'd1;
    end
    unique case ({accept, fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sent_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sent_q   <= sent_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (accept) begin
      mem_q[wr_ptr_q] <= {indication_heard_meth, indication_heard_v};
    end
  end

endmodule

// File: tb/tb_l_class_oc_echo_indication_output.sv
// Randomized self-checking bench for the Echo indication marshaller against a queue model.
module tb_l_class_oc_echo_indication_output;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        h_ena = 1'b0;
  logic [31:0] h_meth = '0;
  logic [31:0] h_v = '0;
  logic        h_rdy;
  logic        p_ena;
  logic [95:0] p_v;
  logic        p_rdy = 1'b0;
  logic        r_en = 1'b0;
  logic        r_rdy;
  logic [31:0] cnt;

  int vectors = 0;
  int errors  = 0;

  logic [63:0] mq[$];
  logic [31:0] mcount = '0;

  l_class_oc_echo_indication_output #(.DEPTH(DEPTH), .HEARD_TAG(32'd1)) dut (
    .CLK                   (clk),
    .RST                   (rst),
    .indication_heard__ENA (h_ena),
    .indication_heard_meth (h_meth),
    .indication_heard_v    (h_v),
    .indication_heard__RDY (h_rdy),
    .pipe_enq__ENA         (p_ena),
    .pipe_enq_v            (p_v),
    .pipe_enq__RDY         (p_rdy),
    .rule_enable           (r_en),
    .rule_ready            (r_rdy),
    .sent_count            (cnt)
  );

  always #5 clk = ~clk;

  function automatic logic exp_rdy();
    return mq.size() < DEPTH;
  endfunction

  function automatic logic exp_guard();
    return (mq.size() != 0) && p_rdy;
  endfunction

  function automatic logic exp_ena();
    return exp_guard() && r_en;
  endfunction

  function automatic logic [95:0] exp_v();
    logic [63:0] h;
    if (mq.size() == 0) return '0;
    h = mq[0];
    return {h[31:0], h[63:32], 32'd1};
  endfunction

  task automatic apply(input logic ena, input logic [31:0] m, input logic [31:0] v,
                       input logic prdy, input logic ren);
    @(negedge clk);
    h_ena = ena; h_meth = m; h_v = v; p_rdy = prdy; r_en = ren;
    #1;
  endtask

  // Advance the model by the decisions implied at the coming edge, then take the edge.
  task automatic tick();
    logic acc, snd;
    acc = h_ena && exp_rdy();
    snd = exp_ena();
    if (snd) begin
      void'(mq.pop_front());
      mcount = mcount + 32'd1;
    end
    if (acc) mq.push_back({h_meth, h_v});
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    h_ena = 1'b0; p_rdy = 1'b0; r_en = 1'b0;
    rst = 1'b1;
    mq.delete();
    mcount = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++; if (h_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b want 1", h_rdy); end
    vectors++; if (p_ena !== 1'b0) begin errors++; $display("FAIL reset_ena got %b want 0", p_ena); end
    vectors++; if (p_v !== 96'd0) begin errors++; $display("FAIL reset_v got %h want 0", p_v); end
    vectors++; if (r_rdy !== 1'b0) begin errors++; $display("FAIL reset_guard got %b want 0", r_rdy); end
    vectors++; if (cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %h want 0", cnt); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    apply(1'b1, 32'h5, 32'hDEADBEEF, 1'b1, 1'b1);
    vectors++; if (p_ena !== 1'b0) begin errors++; $display("FAIL single_nobypass got %b want 0", p_ena); end
    tick();
    apply(1'b0, '0, '0, 1'b1, 1'b1);
    vectors++; if (p_ena !== 1'b1) begin errors++; $display("FAIL single_ena got %b want 1", p_ena); end
    vectors++; if (p_v !== 96'hDEADBEEF_00000005_00000001) begin
      errors++; $display("FAIL single_v got %h want deadbeef0000000500000001", p_v); end
    tick();
    apply(1'b0, '0, '0, 1'b1, 1'b1);
    vectors++; if (cnt !== 32'd1) begin errors++; $display("FAIL single_cnt got %0d want 1", cnt); end
    vectors++; if (p_ena !== 1'b0) begin errors++; $display("FAIL single_empty got %b want 0", p_ena); end
  endtask

  task automatic test_fill();
    apply(1'b1, 32'hA0, 32'hA1, 1'b0, 1'b1); tick();
    apply(1'b1, 32'hB0, 32'hB1, 1'b0, 1'b1); tick();
    apply(1'b1, 32'hC0, 32'hC1, 1'b0, 1'b1);
    vectors++; if (h_rdy !== 1'b0) begin errors++; $display("FAIL fill_rdy got %b want 0", h_rdy); end
    vectors++; if (r_rdy !== 1'b0) begin errors++; $display("FAIL fill_guard got %b want 0", r_rdy); end
    tick();
    apply(1'b0, '0, '0, 1'b1, 1'b1);
    vectors++; if (p_ena !== 1'b1 || p_v !== {32'hA1, 32'hA0, 32'd1}) begin
      errors++; $display("FAIL fill_sendA got %b/%h want 1/%h", p_ena, p_v, {32'hA1, 32'hA0, 32'd1}); end
    vectors++; if (h_rdy !== 1'b0) begin errors++; $display("FAIL fill_rdy_deq got %b want 0", h_rdy); end
    tick();
    apply(1'b0, '0, '0, 1'b1, 1'b1);
    vectors++; if (p_ena !== 1'b1 || p_v !== {32'hB1, 32'hB0, 32'd1}) begin
      errors++; $display("FAIL fill_sendB got %b/%h want 1/%h", p_ena, p_v, {32'hB1, 32'hB0, 32'd1}); end
    tick();
    apply(1'b0, '0, '0, 1'b1, 1'b1);
    vectors++; if (p_ena !== 1'b0 || h_rdy !== 1'b1) begin
      errors++; $display("FAIL fill_drained got ena=%b rdy=%b want 0/1", p_ena, h_rdy); end
    vectors++; if (cnt !== mcount) begin errors++; $display("FAIL fill_cnt got %0d want %0d", cnt, mcount); end
  endtask

  task automatic test_back_to_back();
    apply(1'b1, 32'h11, 32'h12, 1'b0, 1'b1); tick();
    apply(1'b1, 32'h21, 32'h22, 1'b1, 1'b1);
    vectors++; if (p_ena !== 1'b1 || p_v !== {32'h12, 32'h11, 32'd1}) begin
      errors++; $display("FAIL simul_send got %b/%h want 1/%h", p_ena, p_v, {32'h12, 32'h11, 32'd1}); end
    tick();
    apply(1'b0, '0, '0, 1'b0, 1'b1);
    vectors++; if (p_v !== {32'h22, 32'h21, 32'd1} || r_rdy !== 1'b0 || h_rdy !== 1'b1) begin
      errors++; $display("FAIL simul_occ1 got %h/%b/%b want %h/0/1", p_v, r_rdy, h_rdy, {32'h22, 32'h21, 32'd1}); end
    apply(1'b0, '0, '0, 1'b1, 1'b1);
    vectors++; if (p_ena !== 1'b1) begin errors++; $display("FAIL simul_next got %b want 1", p_ena); end
    tick();
  endtask

  task automatic test_stream();
    logic [63:0] stim[100];
    int acc_i = 0;
    int snd_i = 0;
    do_reset();
    for (int i = 0; i < 100; i++) stim[i] = {$urandom(), $urandom()};
    for (int cyc = 0; cyc < 2000 && snd_i < 100; cyc++) begin
      if (acc_i < 100)
        apply(1'b1, stim[acc_i][63:32], stim[acc_i][31:0], cyc[0], 1'b1);
      else
        apply(1'b0, '0, '0, cyc[0], 1'b1);
      if (p_ena === 1'b1) begin
        vectors++;
        if (p_v !== {stim[snd_i][31:0], stim[snd_i][63:32], 32'd1}) begin
          errors++; $display("FAIL stream_order[%0d] got %h want %h", snd_i, p_v,
                             {stim[snd_i][31:0], stim[snd_i][63:32], 32'd1}); end
        snd_i++;
      end
      if (h_ena && exp_rdy()) acc_i++;
      tick();
    end
    apply(1'b0, '0, '0, 1'b0, 1'b0);
    vectors++; if (snd_i != 100) begin errors++; $display("FAIL stream_done got %0d want 100", snd_i); end
    vectors++; if (cnt !== 32'd100) begin errors++; $display("FAIL stream_cnt got %0d want 100", cnt); end
  endtask

  task automatic test_reset_mid();
    apply(1'b1, 32'h31, 32'h32, 1'b0, 1'b1); tick();
    apply(1'b1, 32'h41, 32'h42, 1'b0, 1'b1); tick();
    apply(1'b0, '0, '0, 1'b1, 1'b1);
    vectors++; if (p_ena !== 1'b1) begin errors++; $display("FAIL midrst_pre got %b want 1", p_ena); end
    #1 rst = 1'b1;
    #1;
    vectors++; if (p_ena !== 1'b0 || p_v !== 96'd0 || r_rdy !== 1'b0 || h_rdy !== 1'b1 || cnt !== 32'd0) begin
      errors++; $display("FAIL midrst_out got ena=%b v=%h g=%b rdy=%b cnt=%0d want 0/0/0/1/0",
                         p_ena, p_v, r_rdy, h_rdy, cnt); end
    mq.delete();
    mcount = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, '0, '0, 1'b1, 1'b1);
      vectors++; if (p_ena !== 1'b0) begin errors++; $display("FAIL midrst_post[%0d] got %b want 0", i, p_ena); end
      tick();
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.sent_q = 32'hFFFF_FFFF;
    #1 release dut.sent_q;
    mcount = 32'hFFFF_FFFF;
    apply(1'b1, 32'h77, 32'h88, 1'b1, 1'b1); tick();
    apply(1'b0, '0, '0, 1'b1, 1'b1);
    vectors++; if (cnt !== 32'hFFFF_FFFF || p_ena !== 1'b1) begin
      errors++; $display("FAIL wrap_pre got cnt=%h ena=%b want ffffffff/1", cnt, p_ena); end
    tick();
    apply(1'b0, '0, '0, 1'b1, 1'b1);
    vectors++; if (cnt !== 32'd0) begin errors++; $display("FAIL wrap_cnt got %h want 0", cnt); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      apply(1'($urandom_range(0, 1)), $urandom(), $urandom(),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0));
      vectors++;
      if (h_rdy !== exp_rdy() || r_rdy !== exp_guard() || p_ena !== exp_ena() ||
          p_v !== exp_v() || cnt !== mcount) begin
        errors++;
        $display("FAIL random[%0d] got rdy=%b g=%b ena=%b v=%h cnt=%0d want %b/%b/%b/%h/%0d", i,
                 h_rdy, r_rdy, p_ena, p_v, cnt, exp_rdy(), exp_guard(), exp_ena(), exp_v(), mcount);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_stream();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
